// File: rtl/antic_dlist_fetcher.sv
// ANTIC display-list DMA front end: loads the display-list pointer from a vector,
// then walks the list one byte per phi2 cycle, following jumps and raising NMI.
module antic_dlist_fetcher #(
  parameter logic [15:0] DLIST_VEC = 16'h0000
) (
  input  logic        phi2,
  input  logic        RST,
  input  logic        F_phi0,
  input  logic        LP_L,
  input  logic        RW,
  input  logic        RNMI_L,
  inout  wire  [7:0]  DB,
  output logic [15:0] address,
  output logic [2:0]  AN,
  output logic        halt_L,
  output logic        NMI_L,
  output logic        RDY_L,
  output logic        REF_L,
  output logic        phi0,
  output logic [15:0] printDLIST,
  output logic [1:0]  cstate,
  output logic [7:0]  data
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    PTR_LO = 2'b01,
    PTR_HI = 2'b10,
    INSTR  = 2'b11
  } state_t;

  state_t state;
  logic   jvb_pending;
  logic   nmi_q;
  logic   unused_inputs;

  // The fetcher only ever listens on the data bus.
  assign DB = 8'bzzzz_zzzz;

  assign phi0   = F_phi0;
  assign RDY_L  = 1'b1;
  assign REF_L  = 1'b1;
  assign cstate = state;
  assign unused_inputs = &{1'b0, LP_L, RW};

  // RNMI_L masks the pulse at the edge and also holds the pin high while it is low.
  assign NMI_L = nmi_q | ~RNMI_L;

  always_ff @(posedge phi2 or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      halt_L      <= 1'b1;
      address     <= '0;
      printDLIST  <= '0;
      data        <= '0;
      AN          <= '0;
      nmi_q       <= 1'b1;
      jvb_pending <= 1'b0;
    end else begin
      nmi_q <= 1'b1;
      case (state)
        IDLE: begin
          halt_L  <= 1'b0;
          address <= DLIST_VEC;
          state   <= PTR_LO;
        end
        PTR_LO: begin
          printDLIST[7:0] <= DB;
          data            <= DB;
          address         <= address + 16'd1;
          state           <= PTR_HI;
        end
        PTR_HI: begin
          printDLIST[15:8] <= DB;
          data             <= DB;
          address          <= {DB, printDLIST[7:0]};
          if (jvb_pending) begin
            nmi_q       <= ~RNMI_L;
            jvb_pending <= 1'b0;
          end
          state <= INSTR;
        end
        INSTR: begin
          data    <= DB;
          AN      <= DB[2:0];
          address <= address + 16'd1;
          if (DB[3:0] == 4'h1) begin
            if (DB[6]) jvb_pending <= 1'b1;
            state <= PTR_LO;
          end else begin
            printDLIST <= address + 16'd1;
          end
          if (DB[7]) nmi_q <= ~RNMI_L;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_antic_dlist_fetcher.sv
// Directed bench for antic_dlist_fetcher: per-edge vector tables over small display
// lists, plus hand sequences for async reset, NMI masking and pointer-address wrap.
module tb_antic_dlist_fetcher;

  logic        phi2 = 1'b0;
  logic        rst = 1'b0;
  logic        f_phi0 = 1'b0;
  logic        lp_l = 1'b1;
  logic        rw = 1'b1;
  logic        rnmi_l = 1'b1;
  wire  [7:0]  db;
  logic [15:0] address;
  logic [2:0]  an;
  logic        halt_l, nmi_l, rdy_l, ref_l, phi0;
  logic [15:0] print_dlist;
  logic [1:0]  cstate;
  logic [7:0]  data;

  wire  [7:0]  db2;
  logic [15:0] address2, print_dlist2;
  logic [2:0]  an2;
  logic        halt_l2, nmi_l2, rdy_l2, ref_l2, phi0_2;
  logic [1:0]  cstate2;
  logic [7:0]  data2;

  logic [7:0] mem [65536];

  int unsigned tests = 0;
  int unsigned failures = 0;

  assign db  = !halt_l  ? mem[address]  : 8'bzzzz_zzzz;
  assign db2 = !halt_l2 ? mem[address2] : 8'bzzzz_zzzz;

  antic_dlist_fetcher #(.DLIST_VEC(16'h0000)) dut (
    .phi2(phi2), .RST(rst), .F_phi0(f_phi0), .LP_L(lp_l), .RW(rw), .RNMI_L(rnmi_l),
    .DB(db), .address(address), .AN(an), .halt_L(halt_l), .NMI_L(nmi_l),
    .RDY_L(rdy_l), .REF_L(ref_l), .phi0(phi0), .printDLIST(print_dlist),
    .cstate(cstate), .data(data)
  );

  antic_dlist_fetcher #(.DLIST_VEC(16'hFFFF)) dut_wrap (
    .phi2(phi2), .RST(rst), .F_phi0(f_phi0), .LP_L(lp_l), .RW(rw), .RNMI_L(rnmi_l),
    .DB(db2), .address(address2), .AN(an2), .halt_L(halt_l2), .NMI_L(nmi_l2),
    .RDY_L(rdy_l2), .REF_L(ref_l2), .phi0(phi0_2), .printDLIST(print_dlist2),
    .cstate(cstate2), .data(data2)
  );

  always #5 phi2 = ~phi2;

  typedef struct {
    bit          restart;
    int unsigned img;
    bit          rnmi;
    logic [1:0]  cs;
    logic        halt;
    logic        nmi;
    logic [15:0] addr;
    logic [15:0] pd;
    logic [7:0]  dat;
    logic [2:0]  an;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge phi2);
    @(negedge phi2);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic load_image(input int unsigned img);
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h00;
    mem[16'h0001] = 8'h20;
    case (img)
      0: begin
        mem[16'h2000] = 8'h70; mem[16'h2001] = 8'h70; mem[16'h2002] = 8'h41;
        mem[16'h2003] = 8'h00; mem[16'h2004] = 8'h20;
      end
      1: begin
        mem[16'h2000] = 8'h02; mem[16'h2001] = 8'h82; mem[16'h2002] = 8'h70;
      end
      default: begin
        mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
      end
    endcase
  endtask

  task automatic add(input bit rs, input int unsigned img, input bit rn, input logic [1:0] cs,
                     input logic h, input logic n, input logic [15:0] a, input logic [15:0] p,
                     input logic [7:0] d, input logic [2:0] m);
    vec_t v;
    v.restart = rs; v.img = img; v.rnmi = rn; v.cs = cs; v.halt = h; v.nmi = n;
    v.addr = a; v.pd = p; v.dat = d; v.an = m;
    vecs.push_back(v);
  endtask

  function automatic logic [63:0] pack(input logic [1:0] cs, input logic h, input logic n,
                                       input logic [15:0] a, input logic [15:0] p,
                                       input logic [7:0] d, input logic [2:0] m);
    return {17'd0, cs, h, n, a, p, d, m};
  endfunction

  initial begin
    // Image 0: pointer load, blank lines, then JVB back to 2000.
    add(1, 0, 1, 2'd0, 1, 1, 16'h0000, 16'h0000, 8'h00, 3'd0);
    add(0, 0, 1, 2'd1, 0, 1, 16'h0000, 16'h0000, 8'h00, 3'd0);
    add(0, 0, 1, 2'd2, 0, 1, 16'h0001, 16'h0000, 8'h00, 3'd0);
    add(0, 0, 1, 2'd3, 0, 1, 16'h2000, 16'h2000, 8'h20, 3'd0);
    add(0, 0, 1, 2'd3, 0, 1, 16'h2001, 16'h2001, 8'h70, 3'd0);
    add(0, 0, 1, 2'd3, 0, 1, 16'h2002, 16'h2002, 8'h70, 3'd0);
    add(0, 0, 1, 2'd1, 0, 1, 16'h2003, 16'h2002, 8'h41, 3'd1);
    add(0, 0, 1, 2'd2, 0, 1, 16'h2004, 16'h2000, 8'h00, 3'd1);
    add(0, 0, 1, 2'd3, 0, 0, 16'h2000, 16'h2000, 8'h20, 3'd1);
    add(0, 0, 1, 2'd3, 0, 1, 16'h2001, 16'h2001, 8'h70, 3'd0);
    // Image 1: mode 2, then DLI mode 2, then blank; NMI enabled.
    add(1, 1, 1, 2'd0, 1, 1, 16'h0000, 16'h0000, 8'h00, 3'd0);
    add(0, 1, 1, 2'd1, 0, 1, 16'h0000, 16'h0000, 8'h00, 3'd0);
    add(0, 1, 1, 2'd2, 0, 1, 16'h0001, 16'h0000, 8'h00, 3'd0);
    add(0, 1, 1, 2'd3, 0, 1, 16'h2000, 16'h2000, 8'h20, 3'd0);
    add(0, 1, 1, 2'd3, 0, 1, 16'h2001, 16'h2001, 8'h02, 3'd2);
    add(0, 1, 1, 2'd3, 0, 0, 16'h2002, 16'h2002, 8'h82, 3'd2);
    add(0, 1, 1, 2'd3, 0, 1, 16'h2003, 16'h2003, 8'h70, 3'd0);
    // Image 1 again with RNMI_L held low: DLI must not pulse.
    add(1, 1, 0, 2'd0, 1, 1, 16'h0000, 16'h0000, 8'h00, 3'd0);
    add(0, 1, 0, 2'd1, 0, 1, 16'h0000, 16'h0000, 8'h00, 3'd0);
    add(0, 1, 0, 2'd2, 0, 1, 16'h0001, 16'h0000, 8'h00, 3'd0);
    add(0, 1, 0, 2'd3, 0, 1, 16'h2000, 16'h2000, 8'h20, 3'd0);
    add(0, 1, 0, 2'd3, 0, 1, 16'h2001, 16'h2001, 8'h02, 3'd2);
    add(0, 1, 0, 2'd3, 0, 1, 16'h2002, 16'h2002, 8'h82, 3'd2);
    add(0, 1, 0, 2'd3, 0, 1, 16'h2003, 16'h2003, 8'h70, 3'd0);

    foreach (vecs[i]) begin
      rnmi_l = vecs[i].rnmi;
      if (vecs[i].restart) begin
        load_image(vecs[i].img);
        rst = 1'b0;
        tick();
      end else begin
        tick();
      end
      check($sformatf("vec%0d", i),
            pack(cstate, halt_l, nmi_l, address, print_dlist, data, an),
            pack(vecs[i].cs, vecs[i].halt, vecs[i].nmi, vecs[i].addr, vecs[i].pd,
                 vecs[i].dat, vecs[i].an));
      rst = 1'b1;
    end

    // Async reset between edges while walking in INSTR.
    rnmi_l = 1'b1;
    load_image(0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (4) tick();
    check("walk_before_reset", pack(cstate, halt_l, nmi_l, address, print_dlist, data, an),
          pack(2'd3, 0, 1, 16'h2001, 16'h2001, 8'h70, 3'd0));
    #2 rst = 1'b0;
    #1 check("async_reset", pack(cstate, halt_l, nmi_l, address, print_dlist, data, an),
             pack(2'd0, 1, 1, 16'h0000, 16'h0000, 8'h00, 3'd0));
    @(negedge phi2);
    rst = 1'b1;
    tick();
    check("post_reset_edge1", {62'd0, cstate}, 64'd1);
    check("post_reset_halt", {63'd0, halt_l}, 64'd0);

    // RNMI_L low forces NMI_L high in the middle of a DLI pulse.
    load_image(1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (5) tick();
    check("dli_pulse_low", {63'd0, nmi_l}, 64'd0);
    rnmi_l = 1'b0;
    #1 check("rnmi_forces_high", {63'd0, nmi_l}, 64'd1);
    rnmi_l = 1'b1;

    // Vector at FFFF: pointer high byte fetched from wrapped address 0000.
    load_image(2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("wrap_vec_addr", {48'd0, address2}, 64'h0000_0000_0000_FFFF);
    tick();
    check("wrap_addr", {48'd0, address2}, 64'h0);
    tick();
    check("wrap_ptr", {30'd0, cstate2, print_dlist2, address2}, {30'd0, 2'd3, 16'h1234, 16'h1234});

    // Fixed outputs and phi0 pass-through.
    f_phi0 = 1'b1;
    #1 check("phi0_hi", {63'd0, phi0}, 64'd1);
    f_phi0 = 1'b0;
    #1 check("phi0_lo", {63'd0, phi0}, 64'd0);
    check("rdy_ref", {62'd0, rdy_l, ref_l}, 64'd3);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
